axi4_lite_reduc_reg_bank: RTL and testbench
===========================================

AXI4_LITE_REDUC_REG_BANK -- requirements
Module: axi4_lite_reduc_reg_bank

Interface
REQ-001 Parameter ADDR_BIT_WIDTH, default 8, AXI4-Lite address width; legal range 5..32.
REQ-002 Parameter DATA_BIT_WIDTH, default 32, AXI4-Lite data width; legal values 32 or 64.
REQ-003 Parameter NUM_REGS, default 4, number of data registers and reduction channels; legal range 1..16.
REQ-004 Derived width CNT_W = $clog2(DATA_BIT_WIDTH)+1 and byte stride STRIDE = DATA_BIT_WIDTH/8.
REQ-005 clk  in  1  sole clock; all logic is clocked on posedge.
REQ-006 async_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 s_awaddr/s_awvalid/s_awready  in/in/out  ADDR_BIT_WIDTH/1/1  AXI4-Lite write-address channel.
REQ-008 s_wdata/s_wstrb/s_wvalid/s_wready  in/in/in/out  DATA_BIT_WIDTH/STRIDE/1/1  AXI4-Lite write-data channel.
REQ-009 s_bresp/s_bvalid/s_bready  out/out/in  2/1/1  AXI4-Lite write-response channel.
REQ-010 s_araddr/s_arvalid/s_arready  in/in/out  ADDR_BIT_WIDTH/1/1  AXI4-Lite read-address channel.
REQ-011 s_rdata/s_rresp/s_rvalid/s_rready  out/out/out/in  DATA_BIT_WIDTH/2/1/1  AXI4-Lite read-data channel.
REQ-012 reduc_out  out  NUM_REGS*CNT_W  per-channel result; channel i occupies bits [i*CNT_W +: CNT_W].

Function
REQ-013 Address map, word index = addr / STRIDE (low bits ignored): 0..NUM_REGS-1 = data reg i (RW); NUM_REGS = mode reg (RW); NUM_REGS+1+i = result readback i (RO, see REQ-030); all other indices are out of range.
REQ-014 Mode reg: bits [2i+1:2i] select channel i op: 0 OR-reduce, 1 AND-reduce, 2 XOR-reduce, 3 popcount; unused bits read 0 and ignore writes.
REQ-015 1-bit ops are zero-extended to CNT_W; popcount range is 0..DATA_BIT_WIDTH.
REQ-016 reduc_out is registered: it reflects data/mode values one clk after the write handshake edge that changed them.
REQ-017 Write FSM, states W_IDLE and W_RESP: in W_IDLE, s_awready and s_wready are both 1 only in a cycle where s_awvalid and s_wvalid are both 1; the write commits on that edge and the FSM moves to W_RESP.
REQ-018 In W_RESP: s_bvalid=1 and s_awready=s_wready=0; the FSM returns to W_IDLE on the edge where s_bready=1.
REQ-019 Writes honour s_wstrb byte lanes; strobed-off bytes keep their old value.
REQ-020 Writes to out-of-range or read-only indices: no state change, s_bresp=2'b10 (SLVERR); otherwise 2'b00.
REQ-021 Read FSM, states R_IDLE and R_DATA: in R_IDLE, s_arready=1; on s_arvalid, s_rdata/s_rresp are captured and the FSM moves to R_DATA.
REQ-022 In R_DATA: s_rvalid=1, s_arready=0, s_rdata stable; the FSM returns to R_IDLE on the edge where s_rready=1.
REQ-023 Out-of-range read: s_rdata=0, s_rresp=2'b10.
REQ-024 Read and write handshakes to the same index on the same edge: the read returns the pre-write value.
REQ-025 The read and write FSMs are independent; neither channel stalls the other.

Reset
REQ-026 async_rst_n low forces immediately: data regs=0, FSMs to W_IDLE/R_IDLE, s_bvalid=s_rvalid=0, s_bresp=s_rresp=0, s_rdata=0, reduc_out=0.
REQ-027 Mode field i resets to i mod 4 (OR, AND, XOR, popcount repeating); a transaction in flight during reset is dropped, with no response issued.
REQ-028 Deassertion is used as-is; the instantiating logic synchronises the release.

Configuration
REQ-029 Macro AXI4_LITE_REDUC_REG_BANK_READBACK_EN controls result readback.
REQ-030 When the macro is defined: a read of index NUM_REGS+1+i returns reduc_out channel i zero-extended, with OKAY. When it is undefined: those indices are out of range (REQ-023) and the readback logic is not built.

Verification (DATA_BIT_WIDTH=32, NUM_REGS=4)
REQ-031 Apply reset, then read all indices 0..4 -> reg reads return 0x0; mode reads 0x000000E4; reduc_out=0.
REQ-032 Write 0xFFFFFFFF to idx 1 (mode AND) -> reduc_out ch1=1 one clk after the handshake; write 0xFFFFFFFE -> ch1=0.
REQ-033 Reg0=0, write mode=0x3, then write 0xAABBCCDD to idx0 with wstrb=4'b0010 -> reg0 reads 0x0000CC00; ch0=4.
REQ-034 Write addr 0x40 and read addr 0x40 -> bresp=2'b10, rresp=2'b10, rdata=0, no register change.
REQ-035 Hold s_bready=0 for 5 clk after a write -> s_bvalid stays 1 and s_awready stays 0; a second write is accepted only after s_bready=1.
REQ-036 Pull async_rst_n low while s_rvalid=1 -> s_rvalid=0 without waiting for clk; all outputs at reset values per REQ-026/027.

Source files
------------

// File: rtl/axi4_lite_reduc_reg_bank.sv
// AXI4-Lite register bank with per-register reduction channels (OR/AND/XOR/popcount).
// Optional result readback is enabled by defining AXI4_LITE_REDUC_REG_BANK_READBACK_EN.
module axi4_lite_reduc_lane #(
  parameter int DW = 32,
  parameter int CW = 6
) (
  input  logic [DW-1:0] data,
  input  logic [1:0]    op,
  output logic [CW-1:0] res
);
  always_comb begin
    res = '0;
    case (op)
      2'd0:    res = CW'(|data);
      2'd1:    res = CW'(&data);
      2'd2:    res = CW'(^data);
      default: for (int b = 0; b < DW; b++) res = res + CW'(data[b]);
    endcase
  end
endmodule

module axi4_lite_reduc_reg_bank #(
  parameter int ADDR_BIT_WIDTH = 8,
  parameter int DATA_BIT_WIDTH = 32,
  parameter int NUM_REGS       = 4,
  localparam int CNT_W  = $clog2(DATA_BIT_WIDTH) + 1,
  localparam int STRIDE = DATA_BIT_WIDTH / 8
) (
  input  logic                        clk,
  input  logic                        async_rst_n,
  input  logic [ADDR_BIT_WIDTH-1:0]   s_awaddr,
  input  logic                        s_awvalid,
  output logic                        s_awready,
  input  logic [DATA_BIT_WIDTH-1:0]   s_wdata,
  input  logic [STRIDE-1:0]           s_wstrb,
  input  logic                        s_wvalid,
  output logic                        s_wready,
  output logic [1:0]                  s_bresp,
  output logic                        s_bvalid,
  input  logic                        s_bready,
  input  logic [ADDR_BIT_WIDTH-1:0]   s_araddr,
  input  logic                        s_arvalid,
  output logic                        s_arready,
  output logic [DATA_BIT_WIDTH-1:0]   s_rdata,
  output logic [1:0]                  s_rresp,
  output logic                        s_rvalid,
  input  logic                        s_rready,
  output logic [NUM_REGS*CNT_W-1:0]   reduc_out
);
  localparam int SHIFT = $clog2(STRIDE);
  localparam int MW    = 2 * NUM_REGS;
  localparam int DW    = DATA_BIT_WIDTH;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  // Channel i powers up with op (i mod 4) so every op is exercised out of reset.
  function automatic logic [MW-1:0] mode_init();
    logic [MW-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_REGS; i++) m[2*i +: 2] = 2'(i % 4);
    return m;
  endfunction
  localparam logic [MW-1:0] MODE_INIT = mode_init();

  logic [NUM_REGS-1:0][DW-1:0] regs;
  logic [MW-1:0]               mode;
  logic [NUM_REGS*CNT_W-1:0]   reduc_nxt;
  w_state_t w_state, w_next;
  r_state_t r_state, r_next;
  logic [31:0]   aw_idx, ar_idx;
  logic [DW-1:0] wmask, mode_new, rd_val;
  logic          rd_err;

  assign aw_idx = 32'(s_awaddr >> SHIFT);
  assign ar_idx = 32'(s_araddr >> SHIFT);

  always_comb begin
    wmask = '0;
    for (int b = 0; b < STRIDE; b++) wmask[b*8 +: 8] = {8{s_wstrb[b]}};
  end
  assign mode_new = (DW'(mode) & ~wmask) | (s_wdata & wmask);

  // Write channel FSM
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) w_state <= W_IDLE;
    else              w_state <= w_next;
  end

  always_comb begin
    w_next    = w_state;
    s_awready = 1'b0;
    s_wready  = 1'b0;
    s_bvalid  = 1'b0;
    case (w_state)
      W_IDLE: if (s_awvalid && s_wvalid) begin
        s_awready = 1'b1;
        s_wready  = 1'b1;
        w_next    = W_RESP;
      end
      W_RESP: begin
        s_bvalid = 1'b1;
        if (s_bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      regs    <= '0;
      mode    <= MODE_INIT;
      s_bresp <= 2'b00;
    end else if (s_awready) begin
      s_bresp <= 2'b10;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (aw_idx == 32'(i)) begin
          regs[i] <= (regs[i] & ~wmask) | (s_wdata & wmask);
          s_bresp <= 2'b00;
        end
      end
      if (aw_idx == 32'(NUM_REGS)) begin
        mode    <= mode_new[MW-1:0];
        s_bresp <= 2'b00;
      end
    end
  end

  // Read channel FSM
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) r_state <= R_IDLE;
    else              r_state <= r_next;
  end

  always_comb begin
    r_next    = r_state;
    s_arready = 1'b0;
    s_rvalid  = 1'b0;
    case (r_state)
      R_IDLE: begin
        s_arready = 1'b1;
        if (s_arvalid) r_next = R_DATA;
      end
      R_DATA: begin
        s_rvalid = 1'b1;
        if (s_rready) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    rd_val = '0;
    rd_err = 1'b1;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ar_idx == 32'(i)) begin
        rd_val = regs[i];
        rd_err = 1'b0;
      end
    end
    if (ar_idx == 32'(NUM_REGS)) begin
      rd_val = DW'(mode);
      rd_err = 1'b0;
    end
`ifdef AXI4_LITE_REDUC_REG_BANK_READBACK_EN
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ar_idx == 32'(NUM_REGS + 1 + i)) begin
        rd_val = DW'(reduc_out[i*CNT_W +: CNT_W]);
        rd_err = 1'b0;
      end
    end
`endif
  end

  // Capture uses pre-edge register values, so a same-edge write is not visible.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      s_rdata <= '0;
      s_rresp <= 2'b00;
    end else if (s_arready && s_arvalid) begin
      s_rdata <= rd_val;
      s_rresp <= rd_err ? 2'b10 : 2'b00;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_lane
    axi4_lite_reduc_lane #(.DW(DW), .CW(CNT_W)) u_lane (
      .data (regs[g]),
      .op   (mode[2*g +: 2]),
      .res  (reduc_nxt[g*CNT_W +: CNT_W])
    );
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) reduc_out <= '0;
    else              reduc_out <= reduc_nxt;
  end
endmodule

// File: tb/tb_axi4_lite_reduc_reg_bank.sv
// Scoreboard bench for axi4_lite_reduc_reg_bank (32-bit data, 4 registers).
module tb_axi4_lite_reduc_reg_bank;
  logic        clk = 1'b0;
  logic        async_rst_n = 1'b0;
  logic [7:0]  s_awaddr = '0, s_araddr = '0;
  logic        s_awvalid = 1'b0, s_wvalid = 1'b0, s_arvalid = 1'b0;
  logic        s_bready = 1'b1, s_rready = 1'b0;
  logic [31:0] s_wdata = '0;
  logic [3:0]  s_wstrb = '0;
  logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [1:0]  s_bresp, s_rresp;
  logic [31:0] s_rdata;
  logic [23:0] reduc_out;

  axi4_lite_reduc_reg_bank dut (
    .clk(clk), .async_rst_n(async_rst_n),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .reduc_out(reduc_out)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  bit rr_en = 1'b0;

  typedef struct { logic [1:0] resp; logic [31:0] data; } rexp_t;
  logic [1:0] bq[$];
  rexp_t      rq[$];

  // Reference model
  logic [31:0] mreg[4];
  logic [7:0]  mmode;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] mch(int i);
    logic [31:0] d = mreg[i];
    case ((mmode >> (2*i)) & 8'h3)
      8'd0:    return {5'd0, |d};
      8'd1:    return {5'd0, &d};
      8'd2:    return {5'd0, ^d};
      default: return 6'($countones(d));
    endcase
  endfunction

  function automatic logic [23:0] mreduc();
    return {mch(3), mch(2), mch(1), mch(0)};
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] s);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  function automatic rexp_t mread(int idx);
    rexp_t e;
    e.resp = 2'b00;
    e.data = '0;
    if (idx < 4)       e.data = mreg[idx];
    else if (idx == 4) e.data = {24'd0, mmode};
`ifdef AXI4_LITE_REDUC_REG_BANK_READBACK_EN
    else if (idx <= 8) e.data = {26'd0, mch(idx - 5)};
`endif
    else               e.resp = 2'b10;
    return e;
  endfunction

  task automatic mreset();
    for (int i = 0; i < 4; i++) mreg[i] = '0;
    mmode = 8'hE4;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    int idx = int'(a >> 2);
    logic [31:0] mtmp;
    @(posedge clk); #1;
    s_awaddr = a; s_wdata = d; s_wstrb = s; s_awvalid = 1'b1; s_wvalid = 1'b1;
    #1;
    while (!s_awready) begin
      @(posedge clk); #2;
      if (++n > 100) begin chk("aw_timeout", 1, 0); break; end
    end
    bq.push_back((idx <= 4) ? 2'b00 : 2'b10);
    @(posedge clk);
    if (idx < 4) mreg[idx] = merge(mreg[idx], d, s);
    else if (idx == 4) begin
      mtmp  = merge({24'd0, mmode}, d, s);
      mmode = mtmp[7:0];
    end
    #1; s_awvalid = 1'b0; s_wvalid = 1'b0;
    @(posedge clk); #1;
    chk("reduc_out", reduc_out, mreduc());
  endtask

  task automatic rd(input logic [7:0] a);
    int n = 0;
    @(posedge clk); #1;
    s_araddr = a; s_arvalid = 1'b1;
    #1;
    while (!s_arready) begin
      @(posedge clk); #2;
      if (++n > 100) begin chk("ar_timeout", 1, 0); break; end
    end
    rq.push_back(mread(int'(a >> 2)));
    @(posedge clk); #1;
    s_arvalid = 1'b0;
  endtask

  always begin
    @(posedge clk); #1;
    s_rready = rr_en && ($urandom_range(0, 3) != 0);
  end

  // Monitor: pop and compare on every completed response handshake
  rexp_t re;
  logic [1:0] be;
  always @(negedge clk) begin
    if (async_rst_n && s_bvalid && s_bready) begin
      if (bq.size() == 0) chk("b_unexpected", 1, 0);
      else begin be = bq.pop_front(); chk("bresp", s_bresp, be); end
    end
    if (async_rst_n && s_rvalid && s_rready) begin
      if (rq.size() == 0) chk("r_unexpected", 1, 0);
      else begin
        re = rq.pop_front();
        chk("rresp", s_rresp, re.resp);
        chk("rdata", s_rdata, re.data);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    mreset();
    #12;
    chk("rst_bvalid", s_bvalid, 0);
    chk("rst_rvalid", s_rvalid, 0);
    chk("rst_rdata", s_rdata, 0);
    chk("rst_reduc", reduc_out, 0);
    chk("rst_arready", s_arready, 1);
    @(posedge clk); #1; async_rst_n = 1'b1; rr_en = 1'b1;

    for (int i = 0; i <= 4; i++) rd(8'(i * 4));
    @(posedge clk); #1;
    chk("reduc_after_reset", reduc_out, 0);

    // AND channel: all ones then one bit cleared
    wr(8'h04, 32'hFFFF_FFFF, 4'hF);
    chk("ch1_and_ones", reduc_out[11:6], 6'd1);
    wr(8'h04, 32'hFFFF_FFFE, 4'hF);
    chk("ch1_and_cleared", reduc_out[11:6], 6'd0);

    // Popcount with a single strobed byte
    wr(8'h00, 32'h0, 4'hF);
    wr(8'h10, 32'h3, 4'hF);
    wr(8'h00, 32'hAABB_CCDD, 4'b0010);
    chk("ch0_popcount", reduc_out[5:0], 6'd4);
    rd(8'h00);
    rd(8'h10);

    // Out of range
    wr(8'h40, 32'h1234_5678, 4'hF);
    rd(8'h40);
    for (int i = 0; i <= 4; i++) rd(8'(i * 4));

    // Write-response backpressure
    s_bready = 1'b0;
    wr(8'h08, 32'h0000_00F0, 4'hF);
    fork
      wr(8'h0C, 32'h0F0F_0F0F, 4'hF);
      begin
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk("bp_bvalid", s_bvalid, 1);
          chk("bp_awready", s_awready, 0);
        end
        @(posedge clk); #1; s_bready = 1'b1;
      end
    join

    // Same-edge read and write of one index
    n = 0;
    while (s_rvalid && n < 100) begin @(posedge clk); #1; n++; end
    fork
      wr(8'h08, 32'hDEAD_BEEF, 4'hF);
      rd(8'h08);
    join
    rd(8'h08);

    // Randomized traffic
    for (int k = 0; k < 80; k++) begin
      int idx = $urandom_range(0, 10);
      logic [7:0] a = 8'(idx * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) wr(a, $urandom, 4'($urandom_range(0, 15)));
      else rd(a);
    end

    // Reset while a read response is pending
    n = 0;
    while ((s_rvalid || rq.size() != 0) && n < 100) begin @(posedge clk); #1; n++; end
    rr_en = 1'b0;
    rd(8'h08);
    chk("pre_rst_rvalid", s_rvalid, 1);
    #2; async_rst_n = 1'b0;
    #1;
    chk("arst_rvalid", s_rvalid, 0);
    chk("arst_bvalid", s_bvalid, 0);
    chk("arst_rdata", s_rdata, 0);
    chk("arst_rresp", s_rresp, 0);
    chk("arst_bresp", s_bresp, 0);
    chk("arst_reduc", reduc_out, 0);
    chk("arst_arready", s_arready, 1);
    rq.delete();
    mreset();
    @(posedge clk); #1; async_rst_n = 1'b1; rr_en = 1'b1;
    rd(8'h10);
    rd(8'h08);
    wr(8'h0C, 32'h0000_0007, 4'hF);

    n = 0;
    while ((bq.size() != 0 || rq.size() != 0) && n < 200) begin @(posedge clk); n++; end
    chk("bq_drained", 64'(bq.size()), 0);
    chk("rq_drained", 64'(rq.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
